// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter sequencer and the return-address
// stack it drives: default widths/depth, the sequencer state encoding and the
// operation-priority encoding used to resolve simultaneous op requests.
// Ports: none (package).
// -----------------------------------------------------------------------------
package pc_pkg;

  // Defaults shared with the return-address stack instance.
  localparam int ADDR_W_DEFAULT = 12;
  localparam int DEPTH_DEFAULT  = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    FAULT    = 2'd2
  } pc_state_t;

  // Higher encoding value means higher priority.
  typedef enum logic [2:0] {
    OP_SEQ  = 3'd0,
    OP_BR   = 3'd1,
    OP_JMP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_sel_t;

  // Collapse the one-hot-ish op requests into the single winning operation.
  function automatic op_sel_t sel_op(input logic ret, input logic call,
                                     input logic jmp, input logic br);
    op_sel_t s;
    if (ret) begin
      s = OP_RET;
    end else if (call) begin
      s = OP_CALL;
    end else if (jmp) begin
      s = OP_JMP;
    end else if (br) begin
      s = OP_BR;
    end else begin
      s = OP_SEQ;
    end
    return s;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Bus between the PC sequencer (master) and the return-address stack (slave).
//   stk_push  : one-cycle push strobe, master -> stack
//   stk_pop   : one-cycle pop strobe, master -> stack
//   stk_wdata : return address written with stk_push
//   stk_rdata : stack top-of-stack output, consumed while the pop is in flight
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int ADDR_W = pc_pkg::ADDR_W_DEFAULT
);

  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_wdata;
  logic [ADDR_W-1:0] stk_rdata;

  modport master (
    output stk_push,
    output stk_pop,
    output stk_wdata,
    input  stk_rdata
  );

  modport slave (
    input  stk_push,
    input  stk_pop,
    input  stk_wdata,
    output stk_rdata
  );

endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter / next-address sequencer sitting upstream of the return
// address stack. Generates the fetch address, pushes return addresses on
// calls, pops them on returns, and tracks stack occupancy so that an overflow
// or underflow parks the sequencer in a sticky FAULT state instead of
// corrupting the stack.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : advance enable (ignored while a return is in flight)
//   op_jmp, op_br_taken, op_call, op_ret, target : operation requests
//   pc, pc_valid    : current fetch address and its validity
//   stk (master)    : push/pop/wdata to the stack, rdata back
//   fault           : sticky overflow/underflow flag
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter int                DEPTH    = DEPTH_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               op_jmp,
  input  logic               op_br_taken,
  input  logic               op_call,
  input  logic               op_ret,
  input  logic [ADDR_W-1:0]  target,
  output logic [ADDR_W-1:0]  pc,
  output logic               pc_valid,
  pc_sequencer_if.master     stk,
  output logic               fault
);

  localparam int                DEPTH_W   = $clog2(DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

  pc_state_t          state_r,    state_s;
  logic [ADDR_W-1:0]  pc_r,       pc_s;
  logic               valid_r,    valid_s;
  logic               push_r,     push_s;
  logic               pop_r,      pop_s;
  logic [ADDR_W-1:0]  wdata_r,    wdata_s;
  logic [DEPTH_W-1:0] depth_r,    depth_s;
  logic               fault_r,    fault_s;
  op_sel_t            op_s;
  logic [ADDR_W-1:0]  pc_inc_s;

  assign op_s     = sel_op(op_ret, op_call, op_jmp, op_br_taken);
  // Natural ADDR_W-bit wrap: all-ones steps to zero with no flag.
  assign pc_inc_s = pc_r + ADDR_W'(1);

  // State and output registers; reset overrides everything, including a
  // return that is waiting for stack data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      pc_r    <= RESET_PC;
      valid_r <= 1'b1;
      push_r  <= 1'b0;
      pop_r   <= 1'b0;
      wdata_r <= '0;
      depth_r <= '0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      valid_r <= valid_s;
      push_r  <= push_s;
      pop_r   <= pop_s;
      wdata_r <= wdata_s;
      depth_r <= depth_s;
      fault_r <= fault_s;
    end
  end

  // Next-state / next-output logic. Strobes default low so that each push or
  // pop lasts exactly one cycle.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    valid_s = valid_r;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    wdata_s = wdata_r;
    depth_s = depth_r;
    fault_s = fault_r;

    case (state_r)
      RUN: begin
        if (en) begin
          case (op_s)
            OP_RET: begin
              if (depth_r != {DEPTH_W{1'b0}}) begin
                pop_s   = 1'b1;
                valid_s = 1'b0;
                state_s = RET_WAIT;
              end else begin
                fault_s = 1'b1;
                valid_s = 1'b0;
                state_s = FAULT;
              end
            end
            OP_CALL: begin
              if (depth_r < DEPTH_MAX) begin
                pc_s    = target;
                wdata_s = pc_inc_s;
                push_s  = 1'b1;
                depth_s = depth_r + DEPTH_W'(1);
              end else begin
                fault_s = 1'b1;
                valid_s = 1'b0;
                state_s = FAULT;
              end
            end
            OP_JMP, OP_BR: begin
              pc_s = target;
            end
            OP_SEQ: begin
              pc_s = pc_inc_s;
            end
            default: begin
              fault_s = 1'b1;
              valid_s = 1'b0;
              state_s = FAULT;
            end
          endcase
        end else begin
          pc_s = pc_r;
        end
      end

      // The pop strobe is on the stack this cycle; its top-of-stack output is
      // the return address. en is deliberately not consulted here.
      RET_WAIT: begin
        pc_s    = stk.stk_rdata;
        depth_s = depth_r - DEPTH_W'(1);
        valid_s = 1'b1;
        state_s = RUN;
      end

      FAULT: begin
        valid_s = 1'b0;
        fault_s = 1'b1;
      end

      // Unreachable encoding: park safely.
      default: begin
        valid_s = 1'b0;
        fault_s = 1'b1;
        state_s = FAULT;
      end
    endcase
  end

  assign pc            = pc_r;
  assign pc_valid      = valid_r;
  assign stk.stk_push  = push_r;
  assign stk.stk_pop   = pop_r;
  assign stk.stk_wdata = wdata_r;
  assign fault         = fault_r;

endmodule
